// File: rtl/division_pipe_ctrl_pkg.sv
// Shared state encoding, default sizing and width helpers for the iterative
// restoring divider and its combinational step.
package division_pkg;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        OUTPUT
    } state_t;

    localparam int DEF_DIVIDEND_W = 10;
    localparam int DEF_DIVISOR_W  = 3;
    localparam int DEF_FRAC_W     = 10;

    // Quotient width: integer dividend bits plus fractional bits.
    function automatic int quot_width(input int dividend_w, input int frac_w);
        return dividend_w + frac_w;
    endfunction

    // Step counter must be able to hold the full quotient width itself.
    function automatic int cnt_width(input int qw);
        return $clog2(qw + 1);
    endfunction

endpackage

// File: rtl/division_pipe_ctrl_div_step.sv
// One restoring-division step: shift the next dividend bit into the partial
// remainder and subtract the divisor when the result stays non-negative.
module div_step #(
    parameter int DIVISOR_W = 3
) (
    input  logic [DIVISOR_W:0]   rem,
    input  logic                 bit_in,
    input  logic [DIVISOR_W-1:0] divisor,
    output logic [DIVISOR_W:0]   rem_next,
    output logic                 q_bit
);

    logic [DIVISOR_W+1:0] shifted;

    always_comb begin
        shifted  = {rem, bit_in};
        q_bit    = (shifted >= {2'b00, divisor});
        rem_next = q_bit ? (DIVISOR_W+1)'(shifted - {2'b00, divisor})
                         : shifted[DIVISOR_W:0];
    end

endmodule

// File: rtl/division_pipe_ctrl.sv
// Iterative fixed-point divider with ready/valid handshakes on both sides,
// one quotient bit per cycle, optional early exit and divide-by-zero flag.
module division_pipe_ctrl
    import division_pkg::*;
#(
    parameter int DIVIDEND_W = DEF_DIVIDEND_W,
    parameter int DIVISOR_W  = DEF_DIVISOR_W,
    parameter int FRAC_W     = DEF_FRAC_W,
    parameter bit EARLY_EXIT = 1'b1
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [DIVIDEND_W-1:0]        in_data_1,
    input  logic [DIVISOR_W-1:0]         in_data_2,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [DIVIDEND_W+FRAC_W-1:0] out_data,
    output logic [DIVISOR_W-1:0]         out_rem,
    output logic                         out_div0
);

    localparam int QW    = quot_width(DIVIDEND_W, FRAC_W);
    localparam int CNT_W = cnt_width(QW);

    state_t               state;
    state_t               state_next;
    logic [QW-1:0]        ext;
    logic [QW-1:0]        quot;
    logic [DIVISOR_W:0]   rem;
    logic [DIVISOR_W-1:0] divisor;
    logic [CNT_W-1:0]     count;

    logic [DIVISOR_W:0]   step_rem;
    logic                 step_q;
    logic [QW-1:0]        quot_next;
    logic [CNT_W-1:0]     count_next;
    logic                 calc_done;

    div_step #(
        .DIVISOR_W (DIVISOR_W)
    ) u_step (
        .rem      (rem),
        .bit_in   (ext[QW-1]),
        .divisor  (divisor),
        .rem_next (step_rem),
        .q_bit    (step_q)
    );

    // Early exit is legal once the remainder is zero and no dividend bits remain.
    always_comb begin
        quot_next  = QW'({quot, step_q});
        count_next = count - CNT_W'(1);
        calc_done  = (count_next == '0) ||
                     (EARLY_EXIT && (step_rem == '0) && (ext[QW-2:0] == '0));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_next = (in_data_2 == '0) ? OUTPUT : CALC;
                end
            end
            CALC: begin
                if (calc_done) begin
                    state_next = OUTPUT;
                end
            end
            OUTPUT: begin
                if (out_valid && out_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // A divide-by-zero enters OUTPUT with out_valid still low, so it appears one cycle later.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ext       <= '0;
            quot      <= '0;
            rem       <= '0;
            divisor   <= '0;
            count     <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_rem   <= '0;
            out_div0  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        if (in_data_2 == '0) begin
                            out_data <= '1;
                            out_rem  <= '0;
                            out_div0 <= 1'b1;
                        end else begin
                            ext     <= {in_data_1, {FRAC_W{1'b0}}};
                            rem     <= '0;
                            quot    <= '0;
                            divisor <= in_data_2;
                            count   <= CNT_W'(QW);
                        end
                    end
                end
                CALC: begin
                    rem   <= step_rem;
                    quot  <= quot_next;
                    ext   <= ext << 1;
                    count <= count_next;
                    if (calc_done) begin
                        out_data  <= quot_next << count_next;
                        out_rem   <= step_rem[DIVISOR_W-1:0];
                        out_div0  <= 1'b0;
                        out_valid <= 1'b1;
                    end
                end
                OUTPUT: begin
                    if (!out_valid) begin
                        out_valid <= 1'b1;
                    end else if (out_ready) begin
                        out_valid <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_division_pipe_ctrl.sv
// Self-checking bench: default-width dividers with and without early exit run in
// lockstep on directed cases, plus a randomized sweep on a wider instance.
module tb_division_pipe_ctrl;

    localparam int DW  = 10;
    localparam int VW  = 3;
    localparam int FW  = 10;
    localparam int QW  = DW + FW;
    localparam int WDW = 16;
    localparam int WVW = 8;
    localparam int WFW = 4;
    localparam int WQW = WDW + WFW;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    logic          in_valid = 1'b0;
    logic          out_ready = 1'b0;
    logic [DW-1:0] in_data_1 = '0;
    logic [VW-1:0] in_data_2 = '0;

    logic          a_in_ready, a_out_valid, a_out_div0;
    logic [QW-1:0] a_out_data;
    logic [VW-1:0] a_out_rem;
    logic          b_in_ready, b_out_valid, b_out_div0;
    logic [QW-1:0] b_out_data;
    logic [VW-1:0] b_out_rem;

    logic           w_in_valid = 1'b0;
    logic           w_out_ready = 1'b0;
    logic [WDW-1:0] w_in_data_1 = '0;
    logic [WVW-1:0] w_in_data_2 = '0;
    logic           w_in_ready, w_out_valid, w_out_div0;
    logic [WQW-1:0] w_out_data;
    logic [WVW-1:0] w_out_rem;

    division_pipe_ctrl #(.DIVIDEND_W(DW), .DIVISOR_W(VW), .FRAC_W(FW), .EARLY_EXIT(1'b1)) dut_a (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(a_in_ready),
        .in_data_1(in_data_1), .in_data_2(in_data_2), .out_valid(a_out_valid),
        .out_ready(out_ready), .out_data(a_out_data), .out_rem(a_out_rem), .out_div0(a_out_div0)
    );

    division_pipe_ctrl #(.DIVIDEND_W(DW), .DIVISOR_W(VW), .FRAC_W(FW), .EARLY_EXIT(1'b0)) dut_b (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(b_in_ready),
        .in_data_1(in_data_1), .in_data_2(in_data_2), .out_valid(b_out_valid),
        .out_ready(out_ready), .out_data(b_out_data), .out_rem(b_out_rem), .out_div0(b_out_div0)
    );

    division_pipe_ctrl #(.DIVIDEND_W(WDW), .DIVISOR_W(WVW), .FRAC_W(WFW), .EARLY_EXIT(1'b1)) dut_w (
        .clk(clk), .rst_n(rst_n), .in_valid(w_in_valid), .in_ready(w_in_ready),
        .in_data_1(w_in_data_1), .in_data_2(w_in_data_2), .out_valid(w_out_valid),
        .out_ready(w_out_ready), .out_data(w_out_data), .out_rem(w_out_rem), .out_div0(w_out_div0)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Remainder after k steps is the top k bits of ext modulo the divisor.
    function automatic int model_lat(input longint ext, input longint d, input int qw, input bit ee);
        if (d == 0) return 1;
        if (!ee) return qw;
        for (int k = 1; k <= qw; k++) begin
            longint head = ext >> (qw - k);
            longint tail = ext & ((64'sd1 <<< (qw - k)) - 1);
            if ((head % d == 0) && (tail == 0)) return k;
        end
        return qw;
    endfunction

    task automatic apply_stimulus(input int dividend, input int divisor, input int hold,
                                  input bit noise, input string tag);
        longint ext = longint'(dividend) << FW;
        longint eq  = (divisor == 0) ? ((64'sd1 <<< QW) - 1) : ext / divisor;
        longint er  = (divisor == 0) ? 0 : ext % divisor;
        int     ela = model_lat(ext, divisor, QW, 1'b1);
        int     elb = model_lat(ext, divisor, QW, 1'b0);
        int     la  = 0;
        int     lb  = 0;
        int     cyc = 0;
        check({tag, ".ready_before"}, 64'({a_in_ready, b_in_ready}), 64'b11);
        in_data_1 = DW'(dividend);
        in_data_2 = VW'(divisor);
        in_valid  = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        while ((la == 0 || lb == 0) && cyc < 40) begin
            if (noise) begin
                in_valid  = 1'b1;
                in_data_1 = DW'($urandom);
                in_data_2 = VW'($urandom);
            end
            @(posedge clk); #1;
            in_valid = 1'b0;
            cyc++;
            check({tag, ".busy"}, 64'({a_in_ready, b_in_ready}), 64'b00);
            if (a_out_valid && la == 0) la = cyc;
            if (b_out_valid && lb == 0) lb = cyc;
        end
        check({tag, ".lat_ee"}, 64'(la), 64'(ela));
        check({tag, ".lat_full"}, 64'(lb), 64'(elb));
        for (int i = 0; i < hold; i++) begin
            if (noise) begin
                in_valid  = 1'b1;
                in_data_1 = DW'($urandom);
                in_data_2 = VW'($urandom);
            end
            @(posedge clk); #1;
            in_valid = 1'b0;
            check({tag, ".hold_valid"}, 64'({a_out_valid, b_out_valid}), 64'b11);
            check({tag, ".hold_data"}, 64'(a_out_data), 64'(eq));
        end
        check_output(tag, eq, er, divisor == 0);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check({tag, ".ready_after"}, 64'({a_in_ready, b_in_ready}), 64'b11);
        check({tag, ".valid_after"}, 64'({a_out_valid, b_out_valid}), 64'b00);
    endtask

    task automatic check_output(input string tag, input longint eq, input longint er, input bit ediv0);
        check({tag, ".data_ee"}, 64'(a_out_data), 64'(eq));
        check({tag, ".data_full"}, 64'(b_out_data), 64'(eq));
        check({tag, ".rem_ee"}, 64'(a_out_rem), 64'(er));
        check({tag, ".rem_full"}, 64'(b_out_rem), 64'(er));
        check({tag, ".div0"}, 64'({a_out_div0, b_out_div0}), {62'b0, ediv0, ediv0});
    endtask

    task automatic run_wide(input int dividend, input int divisor, input int hold);
        longint ext = longint'(dividend) << WFW;
        longint eq  = (divisor == 0) ? ((64'sd1 <<< WQW) - 1) : ext / divisor;
        longint er  = (divisor == 0) ? 0 : ext % divisor;
        int     el  = model_lat(ext, divisor, WQW, 1'b1);
        int     lat = 0;
        check("wide.ready_before", 64'(w_in_ready), 64'd1);
        w_in_data_1 = WDW'(dividend);
        w_in_data_2 = WVW'(divisor);
        w_in_valid  = 1'b1;
        @(posedge clk); #1;
        w_in_valid = 1'b0;
        for (int c = 1; c <= 40 && lat == 0; c++) begin
            @(posedge clk); #1;
            if (w_out_valid) lat = c;
        end
        check("wide.lat", 64'(lat), 64'(el));
        check("wide.lat_bound", 64'(lat >= 1 && lat <= WQW), 64'd1);
        repeat (hold) begin
            @(posedge clk); #1;
        end
        check("wide.data", 64'(w_out_data), 64'(eq));
        check("wide.rem", 64'(w_out_rem), 64'(er));
        check("wide.div0", 64'(w_out_div0), 64'(divisor == 0));
        w_out_ready = 1'b1;
        @(posedge clk); #1;
        w_out_ready = 1'b0;
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog expired before the summary");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int dd;
        int dv;
        #12;
        check("reset.ready", 64'({a_in_ready, b_in_ready, w_in_ready}), 64'b111);
        check("reset.valid", 64'({a_out_valid, b_out_valid, w_out_valid}), 64'b000);
        check("reset.data", 64'(a_out_data), 64'd0);
        check("reset.rem_div0", 64'({a_out_rem, a_out_div0}), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        apply_stimulus(1000, 3, 0, 1'b0, "d1000_3");
        check("d1000_3.literal", 64'(a_out_data), 64'h53555);
        apply_stimulus(512, 4, 0, 1'b0, "d512_4");
        check("d512_4.literal", 64'(a_out_data), 64'h20000);
        apply_stimulus(7, 0, 0, 1'b0, "d7_0");
        check("d7_0.literal", 64'(a_out_data), 64'hFFFFF);
        apply_stimulus(1023, 7, 5, 1'b1, "bp1023_7");
        apply_stimulus(0, 5, 0, 1'b0, "d0_5");
        apply_stimulus(7, 0, 2, 1'b0, "d7_0_again");

        in_data_1 = 10'd1000;
        in_data_2 = 3'd3;
        in_valid  = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check("midreset.valid", 64'({a_out_valid, b_out_valid}), 64'b00);
        check("midreset.data", 64'({a_out_data, b_out_data}), 64'd0);
        check("midreset.rem_div0", 64'({a_out_rem, b_out_rem, a_out_div0, b_out_div0}), 64'd0);
        check("midreset.ready", 64'({a_in_ready, b_in_ready}), 64'b11);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        apply_stimulus(6, 2, 1, 1'b0, "d6_2");
        check("d6_2.literal", 64'(a_out_data), 64'h00C00);

        for (int n = 0; n < 30; n++) begin
            case ($urandom_range(0, 3))
                0:       dd = 0;
                1:       dd = int'($urandom_range(1, 15)) << $urandom_range(0, 11);
                default: dd = int'($urandom_range(0, 65535));
            endcase
            dv = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 255));
            run_wide(dd, dv, int'($urandom_range(0, 2)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
